sample_capture_buffer: RTL and testbench

//   Pre/post-trigger capture memory fed directly by the CIC decimator output
//   (decimated sample + transfer strobe).

---
 rtl/sample_capture_buffer.sv | 192 +++++++++++++++++++
 tb/tb_sample_capture_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture_buffer.sv
// Pre/post-trigger capture memory for decimated samples with trigger-aligned readout.
// Optional forced trigger after AUTO_TIMEOUT WAIT samples: define SAMPLE_CAPTURE_AUTO_TRIG_EN.
module sample_capture_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
  ,
  parameter int AUTO_TIMEOUT = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_falling,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  busy,
  output logic                  triggered,
  output logic                  auto_trig,
  output logic                  done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                         state_r;
  logic [ADDR_WIDTH-1:0]          wr_ptr_r;
  logic [ADDR_WIDTH-1:0]          pre_len_r;
  logic [ADDR_WIDTH-1:0]          start_ptr_r;
  logic [ADDR_WIDTH:0]            cnt_r;
  logic [ADDR_WIDTH:0]            cnt_inc_s;
  logic [ADDR_WIDTH:0]            post_len_s;
  logic signed [DATA_WIDTH-1:0]   level_r;
  logic signed [DATA_WIDTH-1:0]   prev_r;
  logic signed [DATA_WIDTH-1:0]   sample_s;
  logic                           falling_r;
  logic                           prev_vld_r;
  logic                           we_s;
  logic                           edge_s;
  logic                           trig_s;
  logic                           rd_fire_s;
  logic [ADDR_WIDTH-1:0]          rd_idx_s;
  logic [DATA_WIDTH-1:0]          mem_r [DEPTH];

  assign sample_s   = sample;
  assign cnt_inc_s  = cnt_r + CNT_ONE;
  assign post_len_s = DEPTH_CNT - {1'b0, pre_len_r};
  assign we_s       = sample_valid && !arm &&
                      ((state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST));

  // Edge test needs a previous sample from this capture, so the first sample never triggers.
  assign edge_s = prev_vld_r &&
                  (falling_r ? ((prev_r >= level_r) && (sample_s < level_r))
                             : ((prev_r < level_r) && (sample_s >= level_r)));

`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_r;
  logic            auto_s;
  assign auto_s = !edge_s && (to_cnt_r == TO_W'(AUTO_TIMEOUT - 1));
  assign trig_s = edge_s || auto_s;
`else
  assign trig_s    = edge_s;
  assign auto_trig = 1'b0;
`endif

  assign rd_fire_s = rd_en && (state_r == ST_DONE);
  assign rd_idx_s  = start_ptr_r + rd_addr;

  // Capture control: state, write pointer, trigger bookkeeping and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= '0;
      pre_len_r   <= '0;
      start_ptr_r <= '0;
      cnt_r       <= '0;
      level_r     <= '0;
      falling_r   <= 1'b0;
      prev_r      <= '0;
      prev_vld_r  <= 1'b0;
      busy        <= 1'b0;
      triggered   <= 1'b0;
      done        <= 1'b0;
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
      to_cnt_r    <= '0;
      auto_trig   <= 1'b0;
`endif
    end else if (arm) begin
      state_r     <= (pretrig_len == '0) ? ST_WAIT : ST_PRE;
      wr_ptr_r    <= '0;
      pre_len_r   <= pretrig_len;
      start_ptr_r <= '0;
      cnt_r       <= '0;
      level_r     <= trig_level;
      falling_r   <= trig_falling;
      prev_vld_r  <= 1'b0;
      busy        <= 1'b1;
      triggered   <= 1'b0;
      done        <= 1'b0;
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
      to_cnt_r    <= '0;
      auto_trig   <= 1'b0;
`endif
    end else if (we_s) begin
      wr_ptr_r   <= wr_ptr_r + 1'b1;
      prev_r     <= sample_s;
      prev_vld_r <= 1'b1;
      case (state_r)
        ST_PRE: begin
          if (cnt_inc_s == {1'b0, pre_len_r}) begin
            state_r <= ST_WAIT;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_WAIT: begin
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
          to_cnt_r <= to_cnt_r + 1'b1;
`endif
          if (trig_s) begin
            triggered   <= 1'b1;
            start_ptr_r <= wr_ptr_r - pre_len_r;
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
            auto_trig   <= auto_s;
`endif
            // With DEPTH-1 pre samples the trigger sample alone completes the frame.
            if (post_len_s == CNT_ONE) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_POST;
              cnt_r   <= CNT_ONE;
            end
          end
        end
        ST_POST: begin
          if (cnt_inc_s == post_len_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Sample storage write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r] <= sample;
    end
  end

  // Registered readout, rotated so logical index 0 is the oldest sample of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_fire_s;
      if (rd_fire_s) begin
        rd_data <= mem_r[rd_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed self-checking bench for sample_capture_buffer (DEPTH=16, 16-bit samples).
module tb_sample_capture_buffer;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [AW-1:0] pretrig_len;
  logic [DW-1:0] trig_level;
  logic          trig_falling;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic          busy;
  logic          triggered;
  logic          auto_trig;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_rd;

  sample_capture_buffer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
    ,
    .AUTO_TIMEOUT(20)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .pretrig_len(pretrig_len),
    .trig_level(trig_level),
    .trig_falling(trig_falling),
    .sample_valid(sample_valid),
    .sample(sample),
    .busy(busy),
    .triggered(triggered),
    .auto_trig(auto_trig),
    .done(done),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic b, input logic t, input logic d);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_triggered"}, 32'(triggered), 32'(t));
    chk({tag, "_done"}, 32'(done), 32'(d));
  endtask

  task automatic do_arm(input int pl, input int lvl, input logic fall);
    arm          = 1'b1;
    pretrig_len  = AW'(pl);
    trig_level   = DW'(lvl);
    trig_falling = fall;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input int v);
    sample_valid = 1'b1;
    sample       = DW'(v);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic read_chk(input int addr, input int exp);
    logic [DW-1:0] e;
    e       = DW'(exp);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_en = 1'b0;
    chk($sformatf("rd_valid%0d", addr), 32'(rd_valid), 32'd1);
    chk($sformatf("rd_data%0d", addr), 32'(rd_data), 32'(e));
    last_rd = e;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; pretrig_len = '0; trig_level = '0; trig_falling = 1'b0;
    sample_valid = 1'b0; sample = '0; rd_en = 1'b0; rd_addr = '0; last_rd = '0;
    tick();
    tick();
    flags("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_auto", 32'(auto_trig), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    tick();
    send(5); send(-5); send(7);
    flags("idle_ignores", 1'b0, 1'b0, 1'b0);

    // Rising ramp, pretrig 4, level 0: trigger on sample 0, frame -4..11
    do_arm(4, 0, 1'b0);
    flags("ramp_armed", 1'b1, 1'b0, 1'b0);
    for (int v = -10; v <= 20; v++) begin
      send(v);
      if (v == -1) chk("ramp_pre_trig", 32'(triggered), 32'd0);
      if (v == 0) flags("ramp_trig", 1'b1, 1'b1, 1'b0);
      if (v == 10) chk("ramp_not_done", 32'(done), 32'd0);
      if (v == 11) flags("ramp_done", 1'b0, 1'b1, 1'b1);
    end
    chk("ramp_auto", 32'(auto_trig), 32'd0);
    for (int i = 0; i < 16; i++) read_chk(i, i - 4);
    tick();
    chk("ramp_rd_valid_low", 32'(rd_valid), 32'd0);

    // Falling edge, pretrig 0, level 5: trigger on 4, frame 4..-11
    do_arm(0, 5, 1'b1);
    flags("fall_armed", 1'b1, 1'b0, 1'b0);
    for (int v = 10; v >= -15; v--) begin
      send(v);
      if (v == 5) chk("fall_pre_trig", 32'(triggered), 32'd0);
      if (v == 4) chk("fall_trig", 32'(triggered), 32'd1);
      if (v == -10) chk("fall_not_done", 32'(done), 32'd0);
      if (v == -11) flags("fall_done", 1'b0, 1'b1, 1'b1);
    end
    read_chk(0, 4);
    read_chk(5, -1);
    read_chk(15, -11);

`ifndef SAMPLE_CAPTURE_AUTO_TRIG_EN
    // Pretrig 8 with 40 sub-level WAIT samples so the pointer wraps before the crossing
    do_arm(8, 100, 1'b0);
    for (int k = 0; k < 48; k++) begin
      send(k);
      if (k == 7) flags("wrap_pre", 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_no_trig", 32'(triggered), 32'd0);
    send(200);
    chk("wrap_trig", 32'(triggered), 32'd1);
    for (int j = 0; j < 7; j++) begin
      send(300 + j);
      if (j == 5) chk("wrap_not_done", 32'(done), 32'd0);
      if (j == 6) chk("wrap_done", 32'(done), 32'd1);
    end
    read_chk(0, 40);
    read_chk(7, 47);
    read_chk(8, 200);
    read_chk(9, 300);
    read_chk(15, 306);
`endif

    // Re-arm during POST with a same-cycle sample: sample dropped, pointer restarts
    do_arm(2, 0, 1'b0);
    send(-5); send(-4); send(-3); send(1);
    flags("rearm_post", 1'b1, 1'b1, 1'b0);
    arm = 1'b1; pretrig_len = AW'(3); trig_level = DW'(0); trig_falling = 1'b0;
    sample_valid = 1'b1; sample = DW'(77);
    tick();
    arm = 1'b0; sample_valid = 1'b0;
    flags("rearm", 1'b1, 1'b0, 1'b0);
    rd_en = 1'b1; rd_addr = AW'(0);
    tick();
    rd_en = 1'b0;
    chk("rd_busy_valid", 32'(rd_valid), 32'd0);
    chk("rd_busy_hold", 32'(rd_data), 32'(last_rd));
    send(-7); send(3);
    chk("pre_ignores_edge", 32'(triggered), 32'd0);
    send(-2); send(5);
    chk("rearm_trig", 32'(triggered), 32'd1);
    for (int j = 0; j < 12; j++) begin
      send(100 + j);
      if (j == 10) chk("rearm_not_done", 32'(done), 32'd0);
      if (j == 11) chk("rearm_done", 32'(done), 32'd1);
    end
    read_chk(0, -7);
    read_chk(1, 3);
    read_chk(2, -2);
    read_chk(3, 5);
    read_chk(15, 111);

    // Reset mid-POST aborts the frame; IDLE then ignores samples
    do_arm(0, 0, 1'b0);
    send(-1); send(1);
    chk("post_trig", 32'(triggered), 32'd1);
    rst = 1'b1; rd_en = 1'b1;
    tick();
    flags("rst_post", 1'b0, 1'b0, 1'b0);
    chk("rst_post_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    tick();
    send(-1); send(1); send(2);
    flags("rst_idle", 1'b0, 1'b0, 1'b0);
    chk("rst_idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_idle_rd_data", 32'(rd_data), 32'd0);
    rd_en = 1'b0;

    // Constant input never crosses: forced trigger only when the timeout is built in
    do_arm(2, 0, 1'b0);
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
    for (int n = 1; n <= 35; n++) begin
      send(3);
      if (n == 21) chk("auto_before", 32'(triggered), 32'd0);
      if (n == 22) begin
        chk("auto_trig_flag", 32'(auto_trig), 32'd1);
        chk("auto_triggered", 32'(triggered), 32'd1);
      end
      if (n == 34) chk("auto_not_done", 32'(done), 32'd0);
      if (n == 35) chk("auto_done", 32'(done), 32'd1);
    end
`else
    for (int n = 1; n <= 40; n++) send(3);
    flags("no_auto", 1'b1, 1'b0, 1'b0);
    chk("no_auto_flag", 32'(auto_trig), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
